// File: rtl/tis_pkg.sv
// -----------------------------------------------------------------------------
// tis_pkg
// Shared definitions for the TIS node datapath:
//   - op_code constants driven by the node sequencer
//   - source/destination code offsets (relative to the NPORTS port codes)
//   - datapath FSM state type
//   - generic symmetric saturation helper (DW+1 -> DW, for DW up to 63)
// -----------------------------------------------------------------------------
package tis_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_NEG = 3'd4;
    localparam logic [2:0] OP_SWP = 3'd5;
    localparam logic [2:0] OP_SAV = 3'd6;

    // Codes 0..NPORTS-1 address neighbour ports; these follow directly after.
    localparam int SRC_ACC_OFS = 0;
    localparam int SRC_IMM_OFS = 1;
    localparam int SRC_NIL_OFS = 2;
    localparam int SRC_ANY_OFS = 3;

    // Working width of the saturation helper; callers sign-extend into it.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_COMMIT
    } state_t;

    // Clamp to the symmetric range [-(2^(dw-1)-1), 2^(dw-1)-1]. The most
    // negative code is excluded so that negating ACC can never overflow.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int dw);
        logic signed [SAT_W-1:0] lim;
        lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
        if (x > lim)       return lim;
        else if (x < -lim) return -lim;
        else               return x;
    endfunction

endpackage

// File: rtl/tis_node_datapath_if.sv
// -----------------------------------------------------------------------------
// tis_node_datapath_if
// Bundles the sequencer op handshake, the neighbour port handshakes and the
// ACC status outputs of one TIS node datapath.
//   slave  : the datapath (tis_node_datapath)
//   master : the environment (sequencer + neighbour links)
// Signals:
//   op_valid/op_ready/op_code/op_src/op_dst/op_imm/op_done : op handshake
//   in_data/in_valid/in_ready                              : inbound words
//   out_data/out_valid/out_ready                           : outbound word
//   acc_out/acc_zero/acc_neg                               : registered ACC
// -----------------------------------------------------------------------------
interface tis_node_datapath_if #(
    parameter int DW     = 8,
    parameter int NPORTS = 4
);
    localparam int SW = $clog2(NPORTS + 4);

    logic                   op_valid;
    logic                   op_ready;
    logic [2:0]             op_code;
    logic [SW-1:0]          op_src;
    logic [SW-1:0]          op_dst;
    logic signed [DW-1:0]   op_imm;
    logic                   op_done;

    logic [NPORTS*DW-1:0]   in_data;
    logic [NPORTS-1:0]      in_valid;
    logic [NPORTS-1:0]      in_ready;

    logic signed [DW-1:0]   out_data;
    logic [NPORTS-1:0]      out_valid;
    logic [NPORTS-1:0]      out_ready;

    logic signed [DW-1:0]   acc_out;
    logic                   acc_zero;
    logic                   acc_neg;

    modport slave (
        input  op_valid, op_code, op_src, op_dst, op_imm,
        input  in_data, in_valid, out_ready,
        output op_ready, op_done, in_ready, out_data, out_valid,
        output acc_out, acc_zero, acc_neg
    );

    modport master (
        output op_valid, op_code, op_src, op_dst, op_imm,
        output in_data, in_valid, out_ready,
        input  op_ready, op_done, in_ready, out_data, out_valid,
        input  acc_out, acc_zero, acc_neg
    );

endinterface

// File: rtl/tis_port_arb.sv
// -----------------------------------------------------------------------------
// tis_port_arb
// Fixed-priority arbiter for ANY-source reads: grants the lowest-index
// requesting port. Purely combinational; grant is one-hot or all-zero.
// Ports:
//   req : per-port request (neighbour in_valid)
//   gnt : one-hot grant
// -----------------------------------------------------------------------------
module tis_port_arb #(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0] req,
    output logic [NPORTS-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tis_node_datapath.sv
// -----------------------------------------------------------------------------
// tis_node_datapath
// TIS-100 style node datapath: owns ACC and BAK, executes one op at a time
// from the sequencer, reads operands from internal sources or neighbour ports
// (valid/ready), writes MOV results to a neighbour port, saturates every ACC
// write to the symmetric signed range.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : tis_node_datapath_if.slave (op handshake, port links, ACC status)
// Op flow: IDLE -accept-> READ (MOV/ADD/SUB) -> WRITE (MOV to port) -> COMMIT,
// or IDLE -> COMMIT directly for NEG/SWP/SAV/NOP. op_done pulses in COMMIT.
// -----------------------------------------------------------------------------
module tis_node_datapath
    import tis_pkg::*;
#(
    parameter int  DW     = 8,
    parameter int  NPORTS = 4,
    localparam int SW     = $clog2(NPORTS + 4)
) (
    input  logic              clk,
    input  logic              reset,
    tis_node_datapath_if.slave bus
);

    localparam logic [SW-1:0] CODE_NPORTS = SW'(NPORTS);
    localparam logic [SW-1:0] CODE_ACC    = SW'(NPORTS + SRC_ACC_OFS);
    localparam logic [SW-1:0] CODE_IMM    = SW'(NPORTS + SRC_IMM_OFS);
    localparam logic [SW-1:0] CODE_ANY    = SW'(NPORTS + SRC_ANY_OFS);

    state_t                 state_q, state_d;
    logic [2:0]             code_q;
    logic [SW-1:0]          src_q, dst_q;
    logic signed [DW-1:0]   imm_q, opnd_q, acc_q, bak_q;

    logic signed [DW-1:0]   cap_val, acc_d, bak_d, port_word;
    logic                   cap;
    logic                   src_is_port, src_is_any, dst_is_port, dst_is_acc;
    logic [NPORTS-1:0]      src_oh, dst_oh, any_gnt, rd_sel;
    logic signed [DW:0]     acc_w, opnd_w;

    function automatic logic signed [DW-1:0] clamp(input logic signed [DW:0] x);
        logic signed [SAT_W-1:0] y;
        y = sat(SAT_W'(x), DW);
        return y[DW-1:0];
    endfunction

    // Codes at or above NPORTS that are not ACC/IMM/ANY fall through to NIL.
    assign src_is_port = (src_q < CODE_NPORTS);
    assign src_is_any  = (src_q == CODE_ANY);
    assign dst_is_port = (dst_q < CODE_NPORTS);
    assign dst_is_acc  = (dst_q == CODE_ACC);

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            src_oh[i] = (src_q == SW'(i));
            dst_oh[i] = (dst_q == SW'(i));
        end
    end

    tis_port_arb #(.NPORTS(NPORTS)) u_arb (
        .req (bus.in_valid),
        .gnt (any_gnt)
    );

    // Ready is only ever offered on the single port being read.
    always_comb begin
        rd_sel = '0;
        if (state_q == ST_READ) begin
            if (src_is_port)     rd_sel = src_oh;
            else if (src_is_any) rd_sel = any_gnt;
        end
    end

    always_comb begin
        port_word = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (rd_sel[i]) port_word = bus.in_data[i*DW +: DW];
        end
    end

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        cap_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op_code)
                        OP_MOV, OP_ADD, OP_SUB: state_d = ST_READ;
                        default:                state_d = ST_COMMIT;
                    endcase
                end
            end
            ST_READ: begin
                if (src_is_port || src_is_any) begin
                    cap     = |(rd_sel & bus.in_valid);
                    cap_val = port_word;
                end else begin
                    cap = 1'b1;
                    case (src_q)
                        CODE_ACC: cap_val = acc_q;
                        CODE_IMM: cap_val = imm_q;
                        default:  cap_val = '0;
                    endcase
                end
                if (cap) begin
                    state_d = (code_q == OP_MOV && dst_is_port) ? ST_WRITE : ST_COMMIT;
                end
            end
            ST_WRITE: begin
                if (|(dst_oh & bus.out_ready)) state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign acc_w  = (DW+1)'(acc_q);
    assign opnd_w = (DW+1)'(opnd_q);

    always_comb begin
        acc_d = acc_q;
        bak_d = bak_q;
        if (state_q == ST_COMMIT) begin
            case (code_q)
                OP_MOV: if (dst_is_acc) acc_d = clamp(opnd_w);
                OP_ADD: acc_d = clamp(acc_w + opnd_w);
                OP_SUB: acc_d = clamp(acc_w - opnd_w);
                OP_NEG: acc_d = clamp(-acc_w);
                OP_SWP: begin
                    acc_d = bak_q;
                    bak_d = acc_q;
                end
                OP_SAV: bak_d = acc_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= OP_NOP;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            bak_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.op_valid) begin
                code_q <= bus.op_code;
                src_q  <= bus.op_src;
                dst_q  <= bus.op_dst;
                imm_q  <= bus.op_imm;
            end
            if (cap) opnd_q <= cap_val;
            acc_q <= acc_d;
            bak_q <= bak_d;
        end
    end

    assign bus.op_ready  = (state_q == ST_IDLE);
    assign bus.op_done   = (state_q == ST_COMMIT);
    assign bus.in_ready  = rd_sel;
    assign bus.out_valid = (state_q == ST_WRITE) ? dst_oh : '0;
    assign bus.out_data  = (state_q == ST_WRITE) ? opnd_q : '0;
    assign bus.acc_out   = acc_q;
    assign bus.acc_zero  = (acc_q == '0);
    assign bus.acc_neg   = acc_q[DW-1];

endmodule

// File: tb/tb_tis_node_datapath.sv
// -----------------------------------------------------------------------------
// tb_tis_node_datapath
// Bench for tis_node_datapath: instance A (DW=8, NPORTS=4) and instance B
// (DW=12, NPORTS=8). Expected ACC values and outbound words are queued when
// each op is issued and compared when the DUT commits / transfers.
// -----------------------------------------------------------------------------
module tb_tis_node_datapath;
    import tis_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tis_node_datapath_if #(.DW(8),  .NPORTS(4)) ia();
    tis_node_datapath_if #(.DW(12), .NPORTS(8)) ib();

    tis_node_datapath #(.DW(8), .NPORTS(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    tis_node_datapath #(.DW(12), .NPORTS(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    typedef struct {
        int     port;
        longint data;
    } xfer_t;

    int      total = 0;
    int      bad   = 0;
    int      cyc   = 0;
    int      t_a, t_b;
    int      nx_a  = 0;
    int      nx_b  = 0;
    longint  acc_qa[$];
    longint  acc_qb[$];
    xfer_t   out_qa[$];
    xfer_t   out_qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ACC scoreboards: the value after the edge that ends COMMIT.
    initial begin
        longint e;
        forever begin
            @(negedge clk);
            if (ia.op_done === 1'b1) begin
                if (acc_qa.size() == 0) check("a_sb_extra", 1, 0);
                else begin
                    e = acc_qa.pop_front();
                    @(posedge clk); #1;
                    check("a_acc",  ia.acc_out,  e);
                    check("a_zero", ia.acc_zero, (e == 0));
                    check("a_neg",  ia.acc_neg,  (e < 0));
                end
            end
        end
    end

    initial begin
        longint e;
        forever begin
            @(negedge clk);
            if (ib.op_done === 1'b1) begin
                if (acc_qb.size() == 0) check("b_sb_extra", 1, 0);
                else begin
                    e = acc_qb.pop_front();
                    @(posedge clk); #1;
                    check("b_acc",  ib.acc_out,  e);
                    check("b_zero", ib.acc_zero, (e == 0));
                    check("b_neg",  ib.acc_neg,  (e < 0));
                end
            end
        end
    end

    // Outbound word scoreboards.
    initial begin
        xfer_t x;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ia.out_valid[i] && ia.out_ready[i]) begin
                    nx_a++;
                    if (out_qa.size() == 0) check("a_out_extra", 1, 0);
                    else begin
                        x = out_qa.pop_front();
                        check("a_out_port", i, x.port);
                        check("a_out_data", ia.out_data, x.data);
                    end
                end
            end
        end
    end

    initial begin
        xfer_t x;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (ib.out_valid[i] && ib.out_ready[i]) begin
                    nx_b++;
                    if (out_qb.size() == 0) check("b_out_extra", 1, 0);
                    else begin
                        x = out_qb.pop_front();
                        check("b_out_port", i, x.port);
                        check("b_out_data", ib.out_data, x.data);
                    end
                end
            end
        end
    end

    // Present an op for one cycle; returns #1 after the accepting edge.
    task automatic start_a(input logic [2:0] c, input int s, input int d,
                           input longint imm, input bit push, input longint e);
        @(posedge clk); #1;
        ia.op_valid = 1'b1;
        ia.op_code  = c;
        ia.op_src   = 3'(s);
        ia.op_dst   = 3'(d);
        ia.op_imm   = 8'(imm);
        t_a = cyc;
        #1 check("a_op_ready", ia.op_ready, 1);
        if (push) acc_qa.push_back(e);
        @(posedge clk); #1;
        ia.op_valid = 1'b0;
    endtask

    task automatic wait_a(input string tag, input int lat);
        int n = 0;
        while (ia.op_done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, cyc - t_a, lat);
        @(posedge clk); #1;
        check({tag, "_pulse"}, ia.op_done, 0);
    endtask

    task automatic start_b(input logic [2:0] c, input int s, input int d,
                           input longint imm, input bit push, input longint e);
        @(posedge clk); #1;
        ib.op_valid = 1'b1;
        ib.op_code  = c;
        ib.op_src   = 4'(s);
        ib.op_dst   = 4'(d);
        ib.op_imm   = 12'(imm);
        t_b = cyc;
        #1 check("b_op_ready", ib.op_ready, 1);
        if (push) acc_qb.push_back(e);
        @(posedge clk); #1;
        ib.op_valid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input int lat);
        int n = 0;
        while (ib.op_done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, cyc - t_b, lat);
        @(posedge clk); #1;
        check({tag, "_pulse"}, ib.op_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Instance A codes: ports 0..3, ACC=4, IMM=5, NIL=6, ANY=7.
    // Instance B codes: ports 0..7, ACC=8, IMM=9, NIL=10, ANY=11.
    initial begin
        reset        = 1'b1;
        ia.op_valid  = 1'b0; ia.op_code = '0; ia.op_src = '0; ia.op_dst = '0;
        ia.op_imm    = '0;   ia.in_data = '0; ia.in_valid = '0; ia.out_ready = '0;
        ib.op_valid  = 1'b0; ib.op_code = '0; ib.op_src = '0; ib.op_dst = '0;
        ib.op_imm    = '0;   ib.in_data = '0; ib.in_valid = '0; ib.out_ready = '0;
        #3;
        check("rst_op_ready",  ia.op_ready,  1);
        check("rst_op_done",   ia.op_done,   0);
        check("rst_in_ready",  ia.in_ready,  0);
        check("rst_out_valid", ia.out_valid, 0);
        check("rst_out_data",  ia.out_data,  0);
        check("rst_acc",       ia.acc_out,   0);
        check("rst_acc_zero",  ia.acc_zero,  1);
        check("rst_acc_neg",   ia.acc_neg,   0);
        check("rst_b_zero",    ib.acc_zero,  1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Saturating arithmetic on ACC.
        start_a(OP_MOV, 5, 4, 100, 1, 100);  wait_a("mov_imm", 2);
        start_a(OP_ADD, 5, 4, 100, 1, 127);  wait_a("add_sat", 2);
        start_a(OP_SUB, 5, 4, 127, 1, 0);    wait_a("sub1", 2);
        start_a(OP_SUB, 5, 4, 127, 1, -127); wait_a("sub2", 2);
        start_a(OP_NEG, 0, 0, 0,   1, 127);  wait_a("neg", 1);

        // Port 1 source, data arrives after 5 stall cycles; port 0 is a decoy.
        ia.in_data  = {8'd0, 8'd0, 8'd0, 8'd33};
        ia.in_valid = 4'b0001;
        start_a(OP_MOV, 1, 4, 0, 1, -127);
        for (int i = 0; i < 5; i++) begin
            #1 check("p1_stall_rdy", ia.in_ready, 4'b0010);
            @(posedge clk); #1;
        end
        ia.in_valid        = 4'b0011;
        ia.in_data[15:8]   = 8'h80;
        #1 check("p1_xfer_rdy", ia.in_ready, 4'b0010);
        @(posedge clk); #1;
        ia.in_valid = '0;
        check("p1_commit_rdy", ia.in_ready, 0);
        wait_a("p1", 7);

        // ANY source: two ports valid, lowest wins.
        ia.in_data  = {8'd11, 8'd9, 8'd0, 8'd0};
        ia.in_valid = 4'b1100;
        #1 check("idle_in_ready", ia.in_ready, 0);
        start_a(OP_MOV, 7, 4, 0, 1, 9);
        #1 check("any_rdy", ia.in_ready, 4'b0100);
        @(posedge clk); #1;
        check("any_commit_rdy", ia.in_ready, 0);
        wait_a("any", 2);
        ia.in_valid = '0;

        // SAV / SWP round trip.
        start_a(OP_MOV, 5, 4, 7, 1, 7); wait_a("mov7", 2);
        start_a(OP_SAV, 0, 0, 0, 1, 7); wait_a("sav", 1);
        start_a(OP_MOV, 5, 4, 3, 1, 3); wait_a("mov3", 2);
        start_a(OP_SWP, 0, 0, 0, 1, 7); wait_a("swp1", 1);
        start_a(OP_SWP, 0, 0, 0, 1, 3); wait_a("swp2", 1);

        // ACC -> port 0 with the neighbour always ready.
        ia.out_ready = 4'b1111;
        out_qa.push_back('{port: 0, data: 3});
        start_a(OP_MOV, 4, 0, 0, 1, 3);
        wait_a("acc2port", 3);
        ia.out_ready = '0;

        // Reset while a MOV IMM 5 -> port 2 is stuck in WRITE.
        start_a(OP_MOV, 5, 2, 5, 0, 0);
        @(posedge clk); #1;
        check("wr_out_valid", ia.out_valid, 4'b0100);
        check("wr_out_data",  ia.out_data,  5);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", ia.out_valid, 0);
        check("mid_rst_out_data",  ia.out_data,  0);
        check("mid_rst_op_ready",  ia.op_ready,  1);
        check("mid_rst_acc",       ia.acc_out,   0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_done", ia.op_done, 0);
        end
        start_a(OP_MOV, 5, 4, 9, 1, 9); wait_a("mov9", 2);
        start_a(OP_SWP, 0, 0, 0, 1, 0); wait_a("swp_bak0", 1);
        start_a(OP_SWP, 0, 0, 0, 1, 9); wait_a("swp_back", 1);

        // Instance B: clamp of the most negative immediate, then ACC -> port 7
        // with out_ready 0,0,1 over the WRITE cycles.
        start_b(OP_MOV, 9, 8, -2048, 1, -2047); wait_b("b_clamp", 2);
        out_qb.push_back('{port: 7, data: -2047});
        start_b(OP_MOV, 8, 7, 0, 1, -2047);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ib.out_ready = 8'h80;
            #1;
            check("b_wr_valid", ib.out_valid, 8'h80);
            check("b_wr_data",  ib.out_data,  -2047);
            @(posedge clk); #1;
        end
        ib.out_ready = '0;
        wait_b("b_wr", 5);

        @(posedge clk); #2;
        check("a_acc_sb_drain", acc_qa.size(), 0);
        check("b_acc_sb_drain", acc_qb.size(), 0);
        check("a_out_sb_drain", out_qa.size(), 0);
        check("b_out_sb_drain", out_qb.size(), 0);
        check("a_xfer_count",   nx_a, 1);
        check("b_xfer_count",   nx_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
